// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// The slave modport is the unit itself; the master modport is the pipeline/memory side.
interface mem_access_unit_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [1:0]  req_size_i;
    logic        req_signed_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        MemRead_o;
    logic        MemWrite_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  req_valid_i, req_write_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i,
        input  mem_rdata_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        output MemRead_o, MemWrite_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output req_valid_i, req_write_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i,
        output mem_rdata_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        input  MemRead_o, MemWrite_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: word-aligned memory accesses, lane extract/extend, RMW for sub-word stores.
// Latency accept->resp: load 2, word store 2, sub-word store 3, error 1 cycle.
// Backpressure: one request in flight, req_ready_o only in IDLE. MAU_PERF_CNT_EN adds load/store counters.
module mem_access_unit #(
    parameter int MEM_BYTES = 32
) (
    input  logic             Clock_i,
    input  logic             Reset_i,
    mem_access_unit_if.slave bus
`ifdef MAU_PERF_CNT_EN
    ,
    output logic [31:0]      load_cnt_o,
    output logic [31:0]      store_cnt_o
`endif
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [1:0]  size_q;
    logic        signed_q, write_q, err_q;
    logic        accept, req_err;
    logic [31:0] req_base;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val, merge_val;

    assign accept   = (state == IDLE) && bus.req_valid_i;
    assign req_base = {bus.req_addr_i[31:2], 2'b00};

    always_comb begin
        req_err = 1'b0;
        case (bus.req_size_i)
            2'b01:   req_err = bus.req_addr_i[0];
            2'b10:   req_err = (bus.req_addr_i[1:0] != 2'b00);
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
        if (req_base > 32'(MEM_BYTES - 4))
            req_err = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.req_valid_i) begin
                if (req_err)
                    state_nxt = RESP;
                else if (bus.req_write_i && bus.req_size_i == 2'b10)
                    state_nxt = WR;
                else
                    state_nxt = RD;
            end
            RD:      state_nxt = write_q ? WR : RESP;
            WR:      state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Lane extraction for loads and lane merge for sub-word stores, both off the word read in RD.
    always_comb begin
        lane_b    = bus.mem_rdata_i[8*addr_q[1:0] +: 8];
        lane_h    = bus.mem_rdata_i[16*addr_q[1] +: 16];
        load_val  = bus.mem_rdata_i;
        merge_val = bus.mem_rdata_i;
        case (size_q)
            2'b00: begin
                load_val = {{24{signed_q & lane_b[7]}}, lane_b};
                merge_val[8*addr_q[1:0] +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_val = {{16{signed_q & lane_h[15]}}, lane_h};
                merge_val[16*addr_q[1] +: 16] = wdata_q[15:0];
            end
            default: begin
                load_val  = bus.mem_rdata_i;
                merge_val = bus.mem_rdata_i;
            end
        endcase
    end

    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            state    <= IDLE;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q   <= bus.req_addr_i;
                wdata_q  <= bus.req_wdata_i;
                size_q   <= bus.req_size_i;
                signed_q <= bus.req_signed_i;
                write_q  <= bus.req_write_i;
                err_q    <= req_err;
                rdata_q  <= '0;
            end else if (state == RD) begin
                if (write_q)
                    wdata_q <= merge_val;
                else
                    rdata_q <= load_val;
            end
        end
    end

    assign bus.req_ready_o  = (state == IDLE);
    assign bus.resp_valid_o = (state == RESP);
    assign bus.resp_err_o   = (state == RESP) && err_q;
    assign bus.resp_rdata_o = (state == RESP) ? rdata_q : 32'h0;
    // Strobes are gated by reset so an in-flight access is dropped in the reset cycle itself.
    assign bus.MemRead_o    = (state == RD) && !Reset_i;
    assign bus.MemWrite_o   = (state == WR) && !Reset_i;
    assign bus.mem_addr_o   = {addr_q[31:2], 2'b00};
    assign bus.mem_wdata_o  = wdata_q;

`ifdef MAU_PERF_CNT_EN
    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            load_cnt_o  <= '0;
            store_cnt_o <= '0;
        end else if (state == RESP && !err_q) begin
            if (write_q)
                store_cnt_o <= store_cnt_o + 32'd1;
            else
                load_cnt_o  <= load_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory (read on negedge, write on posedge).
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mem_access_unit_if bus();

`ifdef MAU_PERF_CNT_EN
    logic [31:0] load_cnt, store_cnt;
`endif

    mem_access_unit #(.MEM_BYTES(32)) dut (
        .Clock_i (clk),
        .Reset_i (rst),
        .bus     (bus)
`ifdef MAU_PERF_CNT_EN
        ,
        .load_cnt_o  (load_cnt),
        .store_cnt_o (store_cnt)
`endif
    );

    logic [31:0] mem [0:7];

    always @(negedge clk)
        if (bus.MemRead_o) bus.mem_rdata_i <= mem[bus.mem_addr_o[4:2]];

    always @(posedge clk)
        if (bus.MemWrite_o) mem[bus.mem_addr_o[4:2]] <= bus.mem_wdata_o;

    int          lat, nrd, nwr;
    logic [31:0] rd, ws, as;
    logic        er, rr;

    // Issue one request (caller sits 1 time unit after a posedge with the unit idle) and observe it.
    task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int o_lat, output logic [31:0] o_rd, output logic o_er,
                           output int o_nrd, output int o_nwr, output logic [31:0] o_ws,
                           output logic [31:0] o_as, output logic o_rr);
        o_lat = 99; o_rd = 32'hFFFF_FFFF; o_er = 1'b0; o_nrd = 0; o_nwr = 0;
        o_ws = 32'h0; o_as = 32'h0; o_rr = 1'b1;
        bus.req_valid_i  = 1'b1;
        bus.req_write_i  = w;
        bus.req_size_i   = sz;
        bus.req_signed_i = sg;
        bus.req_addr_i   = a;
        bus.req_wdata_i  = wd;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (bus.MemRead_o) begin o_nrd++; o_as = bus.mem_addr_o; end
            if (bus.MemWrite_o) begin o_nwr++; o_ws = bus.mem_wdata_o; o_as = bus.mem_addr_o; end
            if (bus.resp_valid_o) begin
                o_lat = i; o_rd = bus.resp_rdata_o; o_er = bus.resp_err_o; o_rr = bus.req_ready_o;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid_i = 1'b0; bus.req_write_i = 1'b0; bus.req_size_i = 2'b00;
        bus.req_signed_i = 1'b0; bus.req_addr_i = 32'h0; bus.req_wdata_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (bus.req_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", bus.req_ready_o); end
        tests++; if (bus.resp_valid_o !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid_o); end
        tests++; if (bus.resp_err_o !== 1'b0) begin fails++; $display("FAIL reset_resp_err got %b want 0", bus.resp_err_o); end
        tests++; if (bus.resp_rdata_o !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", bus.resp_rdata_o); end
        tests++; if (bus.MemRead_o !== 1'b0 || bus.MemWrite_o !== 1'b0) begin
            fails++; $display("FAIL reset_strobes got rd=%b wr=%b want 0/0", bus.MemRead_o, bus.MemWrite_o); end
        rst = 1'b0;
    endtask

    task automatic test_word_store_load();
        run_req(1'b1, 2'b10, 1'b0, 32'd8, 32'hDEADBEEF, lat, rd, er, nrd, nwr, ws, as, rr);
        tests++; if (lat !== 2) begin fails++; $display("FAIL wstore_latency got %0d want 2", lat); end
        tests++; if (nwr !== 1 || nrd !== 0) begin fails++; $display("FAIL wstore_strobes got wr=%0d rd=%0d want 1/0", nwr, nrd); end
        tests++; if (as !== 32'd8) begin fails++; $display("FAIL wstore_addr got %h want 8", as); end
        tests++; if (ws !== 32'hDEADBEEF) begin fails++; $display("FAIL wstore_wdata got %h want deadbeef", ws); end
        tests++; if (er !== 1'b0 || rd !== 32'h0) begin fails++; $display("FAIL wstore_resp got err=%b rdata=%h want 0/0", er, rd); end
        tests++; if (rr !== 1'b0) begin fails++; $display("FAIL resp_ready got %b want 0", rr); end
        tests++; if (bus.resp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
            fails++; $display("FAIL resp_one_cycle got valid=%b ready=%b want 0/1", bus.resp_valid_o, bus.req_ready_o); end
        run_req(1'b0, 2'b10, 1'b0, 32'd8, 32'h0, lat, rd, er, nrd, nwr, ws, as, rr);
        tests++; if (lat !== 2) begin fails++; $display("FAIL wload_latency got %0d want 2", lat); end
        tests++; if (nrd !== 1 || nwr !== 0) begin fails++; $display("FAIL wload_strobes got rd=%0d wr=%0d want 1/0", nrd, nwr); end
        tests++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin fails++; $display("FAIL wload_data got %h err=%b want deadbeef/0", rd, er); end
    endtask

    task automatic test_load_extend();
        logic [31:0] a_t [5]  = '{32'd7, 32'd7, 32'd6, 32'd5, 32'd4};
        logic [1:0]  s_t [5]  = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01};
        logic        g_t [5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] e_t [5]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h0000007F, 32'h00007F01};
        run_req(1'b1, 2'b10, 1'b0, 32'd4, 32'h80FF7F01, lat, rd, er, nrd, nwr, ws, as, rr);
        for (int i = 0; i < 5; i++) begin
            run_req(1'b0, s_t[i], g_t[i], a_t[i], 32'h0, lat, rd, er, nrd, nwr, ws, as, rr);
            tests++; if (rd !== e_t[i] || lat !== 2 || er !== 1'b0) begin
                fails++; $display("FAIL load_ext[%0d] got %h lat=%0d err=%b want %h lat=2 err=0", i, rd, lat, er, e_t[i]); end
        end
    endtask

    task automatic test_rmw();
        run_req(1'b1, 2'b10, 1'b0, 32'd12, 32'h11223344, lat, rd, er, nrd, nwr, ws, as, rr);
        run_req(1'b1, 2'b00, 1'b0, 32'd13, 32'h000000AA, lat, rd, er, nrd, nwr, ws, as, rr);
        tests++; if (lat !== 3) begin fails++; $display("FAIL rmw_latency got %0d want 3", lat); end
        tests++; if (nrd !== 1 || nwr !== 1) begin fails++; $display("FAIL rmw_strobes got rd=%0d wr=%0d want 1/1", nrd, nwr); end
        tests++; if (ws !== 32'h1122AA44 || as !== 32'd12) begin fails++; $display("FAIL rmw_wdata got %h @%h want 1122aa44 @c", ws, as); end
        run_req(1'b0, 2'b10, 1'b0, 32'd12, 32'h0, lat, rd, er, nrd, nwr, ws, as, rr);
        tests++; if (rd !== 32'h1122AA44) begin fails++; $display("FAIL rmw_reload got %h want 1122aa44", rd); end
        run_req(1'b1, 2'b01, 1'b0, 32'd14, 32'hFFFFBEEF, lat, rd, er, nrd, nwr, ws, as, rr);
        tests++; if (ws !== 32'hBEEFAA44 || lat !== 3) begin fails++; $display("FAIL rmw_half got %h lat=%0d want beefaa44 lat=3", ws, lat); end
    endtask

    task automatic test_errors();
        logic        w_t [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0]  s_t [5] = '{2'b01, 2'b10, 2'b10, 2'b11, 2'b00};
        logic [31:0] a_t [5] = '{32'd3, 32'd2, 32'd32, 32'd0, 32'd33};
        for (int i = 0; i < 5; i++) begin
            run_req(w_t[i], s_t[i], 1'b1, a_t[i], 32'h12345678, lat, rd, er, nrd, nwr, ws, as, rr);
            tests++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || nrd !== 0 || nwr !== 0) begin
                fails++; $display("FAIL err[%0d] got err=%b rdata=%h lat=%0d rd=%0d wr=%0d want 1/0/1/0/0",
                                  i, er, rd, lat, nrd, nwr); end
        end
    endtask

    task automatic test_reset_mid();
        logic saw_wr;
        bus.req_valid_i = 1'b1; bus.req_write_i = 1'b1; bus.req_size_i = 2'b00;
        bus.req_signed_i = 1'b0; bus.req_addr_i = 32'd12; bus.req_wdata_i = 32'h00000055;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        @(posedge clk); #1;
        saw_wr = bus.MemWrite_o;
        rst = 1'b1;
        #1;
        tests++; if (saw_wr !== 1'b1 || bus.MemWrite_o !== 1'b0) begin
            fails++; $display("FAIL midrst_strobe got before=%b during=%b want 1/0", saw_wr, bus.MemWrite_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        tests++; if (bus.req_ready_o !== 1'b1 || bus.resp_valid_o !== 1'b0) begin
            fails++; $display("FAIL midrst_state got ready=%b valid=%b want 1/0", bus.req_ready_o, bus.resp_valid_o); end
        run_req(1'b0, 2'b10, 1'b0, 32'd12, 32'h0, lat, rd, er, nrd, nwr, ws, as, rr);
        tests++; if (rd !== 32'hBEEFAA44) begin fails++; $display("FAIL midrst_mem got %h want beefaa44", rd); end
    endtask

`ifdef MAU_PERF_CNT_EN
    task automatic test_perf();
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        tests++; if (load_cnt !== 32'd0 || store_cnt !== 32'd0) begin
            fails++; $display("FAIL perf_reset got %0d/%0d want 0/0", load_cnt, store_cnt); end
        run_req(1'b0, 2'b10, 1'b0, 32'd8,  32'h0, lat, rd, er, nrd, nwr, ws, as, rr);
        run_req(1'b1, 2'b10, 1'b0, 32'd16, 32'h1, lat, rd, er, nrd, nwr, ws, as, rr);
        run_req(1'b0, 2'b00, 1'b1, 32'd5,  32'h0, lat, rd, er, nrd, nwr, ws, as, rr);
        run_req(1'b0, 2'b11, 1'b0, 32'd0,  32'h0, lat, rd, er, nrd, nwr, ws, as, rr);
        run_req(1'b1, 2'b00, 1'b0, 32'd17, 32'h2, lat, rd, er, nrd, nwr, ws, as, rr);
        run_req(1'b0, 2'b01, 1'b0, 32'd6,  32'h0, lat, rd, er, nrd, nwr, ws, as, rr);
        tests++; if (load_cnt !== 32'd3 || store_cnt !== 32'd2) begin
            fails++; $display("FAIL perf_counts got %0d/%0d want 3/2", load_cnt, store_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_word_store_load();
        test_load_extend();
        test_rmw();
        test_errors();
        test_reset_mid();
`ifdef MAU_PERF_CNT_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator-side load/store unit that drives the byte-addressed, little-endian, word-wide data memory on behalf of the pipeline MEM stage.
- Accepts byte, half and word requests.
- Issues only word-aligned memory accesses.
- Extracts and sign/zero-extends load lanes.
- Performs read-modify-write for sub-word stores, since the memory has no byte enables.
- Signals misaligned and out-of-range requests as errors.

Parameters:
MEM_BYTES, 32, memory size in bytes (multiple of 4); valid aligned base addresses are 0..MEM_BYTES-4

Ports:
Clock_i  in  1  clock; memory writes on posedge, reads on negedge
Reset_i  in  1  synchronous active-high reset
req_valid_i  in  1  request present
req_ready_o  out  1  unit can accept (state IDLE)
req_write_i  in  1  1=store, 0=load
req_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved (error)
req_signed_i  in  1  sign-extend load result
req_addr_i  in  32  byte address
req_wdata_i  in  32  store data, low bits used for sub-word
resp_valid_o  out  1  one-cycle completion pulse
resp_rdata_o  out  32  load result; 0 for stores and errors
resp_err_o  out  1  request rejected, qualified by resp_valid_o
MemRead_o  out  1  memory read strobe
MemWrite_o  out  1  memory write strobe
mem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
mem_wdata_o  out  32  write word
mem_rdata_i  in  32  read word, valid by the posedge ending a MemRead_o cycle

Behaviour:
- States: IDLE, RD, WR, RESP.
- Reset: state IDLE; resp_valid_o, resp_err_o, resp_rdata_o = 0.
  - MemRead_o and MemWrite_o are forced 0 in any cycle where Reset_i=1, including mid-RD/WR; the in-flight request is dropped with no response.
- Accept: IDLE with req_valid_i=1. Capture addr, size, signed, write and wdata in that posedge.
- Error check at accept; any error goes IDLE->RESP with resp_err_o=1 and no memory strobe. Error conditions:
  - size=11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - base > MEM_BYTES-4
- Load: IDLE->RD->RESP.
  - RD drives MemRead_o=1 and mem_addr_o=base, then samples mem_rdata_i at the closing posedge.
  - Byte lane = rd[8*addr[1:0]+:8]; half lane = rd[16*addr[1]+:16].
  - Extend per req_signed_i.
- Word store: IDLE->WR->RESP. WR drives MemWrite_o=1, mem_wdata_o=req_wdata.
- Sub-word store: IDLE->RD->WR->RESP.
  - WR data = read word with the addressed lane replaced by wdata[7:0] or wdata[15:0]; other bytes unchanged.
- RESP: resp_valid_o=1 for exactly one cycle, then IDLE. req_ready_o=0 in RESP.
- Latency from the accept edge to resp_valid_o high:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- Back-to-back requests: a new accept is possible the cycle after RESP. There is no pipelining.
- mem_addr_o and mem_wdata_o are don't-care when no strobe is active; they are held stable during a strobe.
- MemRead_o and MemWrite_o are never both 1.

Optional Feature:
MAU_PERF_CNT_EN
- Defined: adds ports load_cnt_o[31:0] and store_cnt_o[31:0].
  - Each increments on resp_valid_o of a non-error load or store, respectively.
  - Both are cleared by Reset_i and wrap from 0xFFFFFFFF to 0.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Word store then load: store addr 8, data 0xDEADBEEF -> MemWrite_o one cycle, base 8, resp 2 cycles after accept. Load word addr 8 -> resp_rdata_o=0xDEADBEEF.
- Signed/unsigned byte: word 0x80FF7F01 at addr 4.
  - Load byte addr 7 signed -> 0xFFFFFF80.
  - Unsigned -> 0x00000080.
  - Half addr 6 signed -> 0xFFFF80FF.
- Sub-word store RMW: word 0x11223344 at addr 12; store byte 0xAA at addr 13.
  - Sequence: RD then WR, with mem_wdata_o=0x1122AA44 and resp 3 cycles after accept.
  - Reload word -> 0x1122AA44.
- Errors: half at addr 3, word at addr 2, word at addr 32 (MEM_BYTES=32), and size=11.
  - Each gives resp_err_o=1, resp_rdata_o=0, 1-cycle latency, and no strobe.
- Reset mid-operation: assert Reset_i during the WR cycle of a sub-word store.
  - Required: MemWrite_o=0 that cycle, no resp_valid_o, req_ready_o=1 next cycle, and the memory word unchanged.
- With MAU_PERF_CNT_EN: 3 loads, 2 stores and 1 error -> load_cnt_o=3, store_cnt_o=2.
